// File: rtl/core_pkg.sv
// Shared core definitions: register addressing, forward-select
// encoding and the hazard scoreboard entry layout.
package core_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int FWD_DEPTH_DEF = 3;

  localparam int FWD_RF = 0;
  localparam int FWD_EX = 1;
  localparam int FWD_DM = 2;
  localparam int FWD_WB = 3;

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ld;
  } sb_entry_t;

  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand priority encoder over the destination scoreboard.
// Youngest matching producer wins; stage-1 load match flags load-use.
module hazard_match #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int ZERO_REG   = 1,
  parameter int SW         = 2
) (
  input  logic                                 id_valid,
  input  logic [REG_ADDR_W-1:0]                rs,
  input  logic                                 use_rs,
  input  logic [FWD_DEPTH:1]                   sb_v,
  input  logic [FWD_DEPTH:1][REG_ADDR_W-1:0]   sb_rd,
  input  logic                                 ex_ld,
  output logic [SW-1:0]                        sel,
  output logic                                 load_hit
);
  import core_pkg::*;

  logic rs_ok;
  logic req;

  // register 0 never produces a dependency when hard-wired to zero
  always_comb begin
    rs_ok = (ZERO_REG == 0) ? 1'b1 : (rs != '0);
    req   = id_valid & use_rs & rs_ok;
  end

  // scan oldest to youngest so the youngest match overrides
  always_comb begin
    sel      = SW'(FWD_RF);
    load_hit = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (req && sb_v[k] && (sb_rd[k] == rs))
        sel = SW'(k);
    end
    if (req && sb_v[1] && (sb_rd[1] == rs) && ex_ld)
      load_hit = 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller: destination scoreboard, EX operand
// forward selects, load-use stall, flush bubbles, stall counter.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int FWD_DEPTH  = core_pkg::FWD_DEPTH_DEF,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16,
  localparam int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rs_b,
  input  logic                  id_use_a,
  input  logic                  id_use_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr,
  input  logic                  id_load,
  input  logic                  flush,
  output logic [SW-1:0]         fwd_sel_a,
  output logic [SW-1:0]         fwd_sel_b,
  output logic                  stall,
  output logic                  issue_valid,
  output logic [CNT_W-1:0]      stall_cnt
);
  import core_pkg::*;

  logic [FWD_DEPTH:1]                 sb_v;
  logic [FWD_DEPTH:1]                 sb_ld;
  logic [FWD_DEPTH:1][REG_ADDR_W-1:0] sb_rd;

  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic          hit_a;
  logic          hit_b;

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_DEPTH  (FWD_DEPTH),
    .ZERO_REG   (ZERO_REG),
    .SW         (SW)
  ) u_match_a (
    .id_valid (id_valid),
    .rs       (id_rs_a),
    .use_rs   (id_use_a),
    .sb_v     (sb_v),
    .sb_rd    (sb_rd),
    .ex_ld    (sb_ld[1]),
    .sel      (sel_a),
    .load_hit (hit_a)
  );

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_DEPTH  (FWD_DEPTH),
    .ZERO_REG   (ZERO_REG),
    .SW         (SW)
  ) u_match_b (
    .id_valid (id_valid),
    .rs       (id_rs_b),
    .use_rs   (id_use_b),
    .sb_v     (sb_v),
    .sb_rd    (sb_rd),
    .ex_ld    (sb_ld[1]),
    .sel      (sel_b),
    .load_hit (hit_b)
  );

  // flush beats stall; everything reads 0 while reset is held
  always_comb begin
    fwd_sel_a   = reset ? sel_a : SW'(FWD_RF);
    fwd_sel_b   = reset ? sel_b : SW'(FWD_RF);
    stall       = reset & (hit_a | hit_b) & ~flush;
    issue_valid = reset & id_valid & ~stall & ~flush;
  end

  // scoreboard shift; stall/flush/idle drops a bubble into EX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_v  <= '0;
      sb_ld <= '0;
      sb_rd <= '0;
    end else begin
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        sb_v[k]  <= sb_v[k-1];
        sb_ld[k] <= sb_ld[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
      sb_v[1]  <= issue_valid & id_wr;
      sb_ld[1] <= id_load;
      sb_rd[1] <= id_rd;
    end
  end

  // saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
